// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between requesters A and B.
// A request in IDLE is granted immediately (gnt pulse, operands registered onto
// the ALU drive), the ALU result is captured at the end of EXEC, and the owner
// receives a done pulse in DONE. Ties are broken round-robin by default.
// Build macro ALU_ARB_FIXED_PRI_EN: A always wins simultaneous requests and the
// round-robin pointer is not built.
// Only DATA_W = 32 is supported.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_a_i,
  input  logic              req_b_i,
  input  logic [2:0]        op_a_i,
  input  logic [2:0]        op_b_i,
  input  logic [DATA_W-1:0] in1_a_i,
  input  logic [DATA_W-1:0] in2_a_i,
  input  logic [DATA_W-1:0] in1_b_i,
  input  logic [DATA_W-1:0] in2_b_i,
  input  logic [4:0]        shamt_a_i,
  input  logic [4:0]        shamt_b_i,
  output logic              gnt_a_o,
  output logic              gnt_b_o,
  output logic [2:0]        alu_op_o,
  output logic [DATA_W-1:0] alu_in1_o,
  output logic [DATA_W-1:0] alu_in2_o,
  output logic [4:0]        alu_shamt_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_zero_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              done_a_o,
  output logic              done_b_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grantA, grantB;
  logic              tieWinA;
  logic              ownerB_q;
  logic [2:0]        aluOp_q;
  logic [DATA_W-1:0] aluIn1_q, aluIn2_q;
  logic [4:0]        aluShamt_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;

`ifdef ALU_ARB_FIXED_PRI_EN
  // Fixed priority: requester A takes every tie, so no history is kept.
  assign tieWinA = 1'b1;
`else
  logic lastB_q;

  // Round-robin pointer remembers who was granted last; it starts at B so
  // that A wins the very first tie after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lastB_q <= 1'b1;
    end else if (grantA) begin
      lastB_q <= 1'b0;
    end else if (grantB) begin
      lastB_q <= 1'b1;
    end
  end

  assign tieWinA = lastB_q;
`endif

  // Next-state and grant decision: grants only come from IDLE and are
  // suppressed while reset is high so reset beats any concurrent request.
  always_comb begin
    state_d = state_q;
    grantA  = 1'b0;
    grantB  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset_i) begin
          if (req_a_i && req_b_i) begin
            grantA = tieWinA;
            grantB = !tieWinA;
          end else begin
            grantA = req_a_i;
            grantB = req_b_i;
          end
        end
        if (grantA || grantB) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the ALU drive, owner and result registers. The ALU
  // drive is loaded on a grant and held through EXEC; the result is captured
  // at the end of EXEC and held until the next capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ownerB_q   <= 1'b0;
      aluOp_q    <= 3'd0;
      aluIn1_q   <= '0;
      aluIn2_q   <= '0;
      aluShamt_q <= 5'd0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grantA) begin
        ownerB_q   <= 1'b0;
        aluOp_q    <= op_a_i;
        aluIn1_q   <= in1_a_i;
        aluIn2_q   <= in2_a_i;
        aluShamt_q <= shamt_a_i;
      end else if (grantB) begin
        ownerB_q   <= 1'b1;
        aluOp_q    <= op_b_i;
        aluIn1_q   <= in1_b_i;
        aluIn2_q   <= in2_b_i;
        aluShamt_q <= shamt_b_i;
      end
      if (state_q == EXEC) begin
        result_q <= alu_out_i;
        zero_q   <= alu_zero_i;
      end
    end
  end

  assign gnt_a_o     = grantA;
  assign gnt_b_o     = grantB;
  assign alu_op_o    = aluOp_q;
  assign alu_in1_o   = aluIn1_q;
  assign alu_in2_o   = aluIn2_q;
  assign alu_shamt_o = aluShamt_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign done_a_o    = (state_q == DONE) && !ownerB_q && !reset_i;
  assign done_b_o    = (state_q == DONE) && ownerB_q && !reset_i;
  assign busy_o      = (state_q != IDLE) && !reset_i;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; SHALL support only 32.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_a / req_b  input  1 each  operation request from requester A / B; held high until granted.
REQ-005 op_a / op_b  input  3 each  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 compare, 7 slt.
REQ-006 in1_a, in2_a / in1_b, in2_b  input  DATA_W each  operands.
REQ-007 shamt_a / shamt_b  input  5 each  shift amount.
REQ-008 gnt_a / gnt_b  output  1 each  one-cycle grant pulse; operands sampled that cycle.
REQ-009 alu_op  output  3, alu_in1 / alu_in2  output  DATA_W, alu_shamt  output  5: registered drive to the shared ALU.
REQ-010 alu_out  input  DATA_W, alu_zero  input  1: combinational ALU result and equality flag.
REQ-011 result  output  DATA_W, zero  output  1: captured ALU result and flag, held until next capture.
REQ-012 done_a / done_b  output  1 each  one-cycle completion pulse to the owning requester.
REQ-013 busy  output  1  high in EXEC and DONE states.

Function
REQ-014 FSM SHALL have states IDLE, EXEC, DONE.
REQ-015 IDLE: if any req high, SHALL pulse exactly one gnt, latch that requester's op/in1/in2/shamt into alu_* registers, record owner, go to EXEC; else stay IDLE.
REQ-016 EXEC: SHALL hold alu_* stable one cycle, capture alu_out into result and alu_zero into zero at the clock edge, go to DONE.
REQ-017 DONE: SHALL pulse done of the recorded owner only, go to IDLE; no grant in DONE.
REQ-018 Latency: grant in cycle N, done and valid result in cycle N+2; next grant no earlier than N+3.
REQ-019 Arbitration default: round-robin; single request granted immediately; simultaneous requests granted to the requester not granted last.
REQ-020 Request arriving during EXEC/DONE SHALL be ignored until IDLE; no gnt SHALL be issued while busy.
REQ-021 gnt_a and gnt_b SHALL never be high together; done_a and done_b SHALL never be high together.
REQ-022 Opcode 6: result SHALL be captured unmodified from alu_out (don't-care value); zero SHALL carry alu_zero.
REQ-023 Requester dropping req before grant SHALL lose the request with no side effect.

Reset
REQ-024 On reset: state IDLE; gnt_a, gnt_b, done_a, done_b, busy = 0; alu_op = 0, alu_in1 = alu_in2 = 0, alu_shamt = 0; result = 0; zero = 0; last-grant pointer = B (A wins first tie).
REQ-025 Reset during EXEC or DONE SHALL abort the operation; no done pulse SHALL follow; result SHALL read 0.
REQ-026 reset SHALL dominate any concurrent req in the same cycle.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRI_EN defined: fixed priority, A always wins simultaneous requests, pointer unused.
REQ-028 Macro undefined: round-robin per REQ-019.

Verification
REQ-029 Reset, then req_a=1, op_a=0, in1_a=5, in2_a=7 -> gnt_a cycle 1, done_a cycle 3, result=12, zero=0.
REQ-030 req_a and req_b both held after reset (A: op 1, 9-9; B: op 3, 0xF0|0x0F) -> order A, B; A result=0 with zero=1 (9==9), B result=0xFF; third tie granted to A.
REQ-031 req_b op 4, in1_b=1, shamt_b=31 while A granted -> gnt_b only after A's done; B result=0x80000000.
REQ-032 op 7, in1=3, in2=10 -> result=1; op 6, in1=in2=42 -> zero=1.
REQ-033 Assert reset in EXEC cycle of a granted add -> no done pulse, result=0, busy=0 next cycle.
REQ-034 Build with ALU_ARB_FIXED_PRI_EN, both reqs held continuously -> A granted every arbitration, B never granted.
